nios_led3_key_pio: RTL and testbench

NIOS_LED3_KEY_PIO -- requirements
Module: nios_led3_key_pio

---
 rtl/nios_led3_key_pio.sv | 97 +++++++++
 tb/tb_nios_led3_key_pio.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_led3_key_pio.sv
// Debounced key PIO with edge capture and a maskable level interrupt.
// Avalon-MM slave, zero wait states; keys idle high.
module nios_led3_key_pio #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_det, clr;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             irq_q, irq_d;
  logic             wr;
  logic [31:0]      rd;
  logic             unused_wdata;

  // Counter runs only while the synchronized bit disagrees with the filtered bit.
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != filt_q[b]) begin
        if (cnt_q[b] == TC) filt_d[b] = sync2_q[b];
        else                cnt_d[b] = cnt_q[b] + CW'(1);
      end
    end
  end

  always_comb begin
    if (EDGE_TYPE == 0)      edge_det = filt_q & ~dly_q;
    else if (EDGE_TYPE == 1) edge_det = ~filt_q & dly_q;
    else                     edge_det = filt_q ^ dly_q;
  end

  assign wr     = chipselect & ~write_n;
  assign clr    = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign cap_d  = (cap_q & ~clr) | edge_det;
  assign mask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  assign irq_d  = |(cap_q & mask_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      dly_q   <= '1;
      cap_q   <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      dly_q   <= filt_q;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  always_comb begin
    rd = '0;
    if (chipselect) begin
      case (address)
        2'd0:    rd[WIDTH-1:0] = filt_q;
        2'd2:    rd[WIDTH-1:0] = mask_q;
        2'd3:    rd[WIDTH-1:0] = cap_q;
        default: rd = '0;
      endcase
    end
  end

  assign readdata     = rd;
  assign irq          = irq_q;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_nios_led3_key_pio.sv
// Bench for nios_led3_key_pio: three instances (falling/any/rising edge) share all stimulus
// and are checked every cycle against a sliding-window debounce model.
module tb_nios_led3_key_pio;
  localparam int NI = 3;
  localparam int HL = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] rd [NI];
  logic        irq_w [NI];

  int et_a [NI] = '{1, 2, 0};
  int dc_a [NI] = '{4, 4, 16};
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_led3_key_pio #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(4)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[0]), .in_port(in_port), .irq(irq_w[0]));
  nios_led3_key_pio #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[1]), .in_port(in_port), .irq(irq_w[1]));
  nios_led3_key_pio #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[2]), .in_port(in_port), .irq(irq_w[2]));

  // hist[0] is the newest in_port sample; hist[1] is what the filter acts on this edge.
  logic [3:0] hist [HL];
  logic [3:0] m_filt [NI];
  logic [3:0] m_prev [NI];
  logic [3:0] m_mask [NI];
  logic [3:0] m_cap  [NI];
  logic       m_irq  [NI];

  always @(posedge clk or posedge reset) begin : model
    logic [3:0] ev, clr, nf;
    logic       wr, same;
    if (reset) begin
      for (int j = 0; j < HL; j++) hist[j] <= 4'hF;
      for (int i = 0; i < NI; i++) begin
        m_filt[i] <= 4'hF; m_prev[i] <= 4'hF; m_mask[i] <= 4'h0; m_cap[i] <= 4'h0; m_irq[i] <= 1'b0;
      end
    end else begin
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
      for (int i = 0; i < NI; i++) begin
        case (et_a[i])
          0:       ev = m_filt[i] & ~m_prev[i];
          1:       ev = ~m_filt[i] & m_prev[i];
          default: ev = m_filt[i] ^ m_prev[i];
        endcase
        m_irq[i] <= |(m_cap[i] & m_mask[i]);
        m_cap[i] <= (m_cap[i] & ~clr) | ev;
        if (wr && address == 2'd2) m_mask[i] <= writedata[3:0];
        nf = m_filt[i];
        for (int b = 0; b < 4; b++) begin
          same = 1'b1;
          for (int j = 2; j <= dc_a[i]; j++) if (hist[j][b] != hist[1][b]) same = 1'b0;
          if (same && hist[1][b] != m_filt[i][b]) nf[b] = hist[1][b];
        end
        m_prev[i] <= m_filt[i];
        m_filt[i] <= nf;
      end
      for (int j = HL - 1; j > 0; j--) hist[j] <= hist[j-1];
      hist[0] <= in_port;
    end
  end

  function automatic logic [31:0] exp_rd(input int i);
    logic [31:0] r;
    r = 32'd0;
    if (chipselect) begin
      case (address)
        2'd0:    r[3:0] = m_filt[i];
        2'd2:    r[3:0] = m_mask[i];
        2'd3:    r[3:0] = m_cap[i];
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rd_u%0d_a%0d", i, address), rd[i], exp_rd(i));
      chk($sformatf("irq_u%0d", i), {31'd0, irq_w[i]}, {31'd0, m_irq[i]});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick(1);
    write_n = 1'b1; chipselect = 1'b0;
  endtask

  task automatic do_reset();
    chipselect = 1'b0; write_n = 1'b1; in_port = 4'hF;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  int hold [4];

  initial begin
    tick(2);
    chk("rst_irq_held", {31'd0, irq_w[0]}, 32'd0);
    reset = 1'b0;
    set_rd(2'd0); chk("rst_filt", rd[0], 32'hF);
    set_rd(2'd1); chk("rst_addr1", rd[0], 32'h0);
    set_rd(2'd2); chk("rst_mask", rd[0], 32'h0);
    set_rd(2'd3); chk("rst_cap", rd[0], 32'h0);
    chipselect = 1'b0; address = 2'd0; #1;
    chk("cs_low_rd", rd[0], 32'h0);

    // F->E held: filtered value changes on the 6th edge, capture one edge later, irq one after that
    bus_wr(2'd2, 32'h1);
    bus_wr(2'd0, 32'h5);
    in_port = 4'hE;
    tick(5); set_rd(2'd0); chk("lat_edge5", rd[0], 32'hF);
    tick(1); #1;           chk("lat_edge6", rd[0], 32'hE);
    chk("model_filt_edge6", {28'd0, m_filt[0]}, 32'hE);
    tick(1); set_rd(2'd3); chk("cap_set", rd[0], 32'h1); chk("irq_before", {31'd0, irq_w[0]}, 32'd0);
    tick(1); #1;           chk("irq_after_cap", {31'd0, irq_w[0]}, 32'd1);
    chk("model_irq", {31'd0, m_irq[0]}, 32'd1);
    bus_wr(2'd3, 32'h1);
    set_rd(2'd3); chk("cap_cleared", rd[0], 32'h0); chk("irq_still", {31'd0, irq_w[0]}, 32'd1);
    tick(1); #1;  chk("irq_after_clr", {31'd0, irq_w[0]}, 32'd0);

    // a 3-cycle glitch on bit 1 must be filtered out
    do_reset();
    bus_wr(2'd2, 32'hF);
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
    for (int k = 0; k < 10; k++) begin
      tick(1); set_rd(2'd0); chk("glitch_filt", rd[0], 32'hF);
    end
    set_rd(2'd3); chk("glitch_cap", rd[0], 32'h0); chk("glitch_cap_any", rd[1], 32'h0);
    chk("glitch_irq", {31'd0, irq_w[0]}, 32'd0);

    // capture and clear of bit 2 land on the same edge: set wins
    do_reset();
    in_port = 4'hB;
    tick(6);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h4;
    tick(1);
    write_n = 1'b1; #1;
    chk("set_wins_fall", rd[0], 32'h4); chk("set_wins_any", rd[1], 32'h4);

    // press and release of bit 3: any-edge instance captures both, falling-edge only the press
    do_reset();
    in_port = 4'h7;
    tick(7); set_rd(2'd3); chk("press_fall", rd[0], 32'h8); chk("press_any", rd[1], 32'h8);
    bus_wr(2'd3, 32'h8);
    set_rd(2'd3); chk("press_clr_any", rd[1], 32'h0);
    in_port = 4'hF;
    tick(7); #1; chk("release_any", rd[1], 32'h8); chk("release_fall", rd[0], 32'h0);

    // reset during debounce with an irq pending discards everything at once
    bus_wr(2'd2, 32'hF);
    tick(1); #1; chk("pend_irq", {31'd0, irq_w[1]}, 32'd1);
    in_port = 4'h0;
    tick(3);
    reset = 1'b1;
    set_rd(2'd3);
    chk("async_irq", {31'd0, irq_w[1]}, 32'd0); chk("async_cap", rd[1], 32'h0);
    tick(2);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1); set_rd(2'd3);
      chk("post_rst_cap", rd[0], 32'h0); chk("post_rst_irq", {31'd0, irq_w[0]}, 32'd0);
    end
    tick(1); set_rd(2'd3); chk("post_rst_full", rd[0], 32'hF); chk("post_rst_full_any", rd[1], 32'hF);

    // randomized traffic
    do_reset();
    for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 24);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          in_port[b] = ~in_port[b];
          hold[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(4, 24);
        end
      end
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      tick(1);
    end
    reset = 1'b0;
    chipselect = 1'b0; write_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
